instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instruction_fetch_queue.sv | 103 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions.
// Holds the fetch FSM state type, the instruction/address widths, the default
// fetch-queue depth and a small PC helper used by the fetch stage.
package pipeline_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int FETCH_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Sequential PC of the next instruction; wraps modulo 2^32.
    function automatic logic [ADDR_WIDTH-1:0] pc_plus4(input logic [ADDR_WIDTH-1:0] pc);
        return pc + ADDR_WIDTH'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   clear                - drop all entries at the next edge (has priority)
//   push, push_pc/instr  - write one entry at the tail
//   pop                  - retire the head entry (ignored when empty)
//   head_pc, head_instr  - head entry contents
//   count, full, empty   - occupancy
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [ADDR_WIDTH-1:0]        push_pc,
    input  logic [INSTR_WIDTH-1:0]       push_instr,
    input  logic                         pop,
    output logic [ADDR_WIDTH-1:0]        head_pc,
    output logic [INSTR_WIDTH-1:0]       head_instr,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH+INSTR_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= {push_pc, push_instr};
    end

    assign {head_pc, head_instr} = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage with a small queue of fetched instructions.
// Issues one request at a time to instruction memory, pushes each accepted
// {pc, instr} into a fetch_fifo and presents the head entry to decode.
// A Flush discards queued entries; a request already in flight is completed
// on the memory side and its data thrown away (DROP state).
// Ports:
//   Clk, Reset (async, active-low)
//   currAddress            - PC from Program_Counter
//   Flush                  - redirect, discards fetched and in-flight work
//   PCWre_from_Fetch_Unit  - PC advance pulse, one per accepted fetch
//   IMem_Req/Addr/Ack/RData- instruction memory request/ack channel
//   ID_Stall               - decode refuses head entry
//   IF_Valid/Instruction/PC/PCadd4 - head entry towards decode
module instruction_fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] currAddress,
    input  logic        Flush,
    output logic        PCWre_from_Fetch_Unit,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_RData,
    input  logic        ID_Stall,
    output logic        IF_Valid,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCadd4
);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Address is captured once at issue and held for the whole request.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)     IMem_Addr <= '0;
        else if (issue) IMem_Addr <= currAddress;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                // Only one request outstanding and only into a free slot,
                // so the queue can never overflow.
                if (!fifo_full && !Flush) begin
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (IMem_Ack)   state_next = IDLE;
                else if (Flush) state_next = DROP;
            end
            DROP: begin
                if (IMem_Ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request stays up through DROP so memory sees the transaction complete.
    assign IMem_Req              = (state != IDLE);
    assign PCWre_from_Fetch_Unit = (state == REQ) & IMem_Ack & ~Flush;
    assign push                  = PCWre_from_Fetch_Unit;
    assign pop                   = ~fifo_empty & ~ID_Stall & ~Flush;
    assign IF_Valid              = (fifo_count != '0);
    assign IF_PCadd4             = pc_plus4(IF_PC);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (Clk),
        .rst_n      (Reset),
        .clear      (Flush),
        .push       (push),
        .push_pc    (IMem_Addr),
        .push_instr (IMem_RData),
        .pop        (pop),
        .head_pc    (IF_PC),
        .head_instr (IF_Instruction),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic [31:0] currAddress;
    logic        Flush;
    logic        PCWre_from_Fetch_Unit;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_RData;
    logic        ID_Stall;
    logic        IF_Valid;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCadd4;

    instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .currAddress           (currAddress),
        .Flush                 (Flush),
        .PCWre_from_Fetch_Unit (PCWre_from_Fetch_Unit),
        .IMem_Req              (IMem_Req),
        .IMem_Addr             (IMem_Addr),
        .IMem_Ack              (IMem_Ack),
        .IMem_RData            (IMem_RData),
        .ID_Stall              (ID_Stall),
        .IF_Valid              (IF_Valid),
        .IF_Instruction        (IF_Instruction),
        .IF_PC                 (IF_PC),
        .IF_PCadd4             (IF_PCadd4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: queue of fetched entries plus the outstanding request.
    ent_t        q[$];
    logic        m_out;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] pc_src;
    logic [31:0] flush_target;

    int          n_checks;
    int          n_errors;
    int          pw_count;
    logic [31:0] pops[$];

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_pcwre;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;
    logic [31:0] obs_pcadd4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs against model, advance model.
    task automatic cycle(input logic flush, input logic ack, input logic stall,
                         input logic [31:0] rdata);
        int   sz;
        logic pw;
        @(negedge Clk);
        Flush       = flush;
        IMem_Ack    = ack;
        ID_Stall    = stall;
        IMem_RData  = rdata;
        currAddress = pc_src;
        #1;
        obs_req    = IMem_Req;
        obs_addr   = IMem_Addr;
        obs_pcwre  = PCWre_from_Fetch_Unit;
        obs_valid  = IF_Valid;
        obs_pc     = IF_PC;
        obs_instr  = IF_Instruction;
        obs_pcadd4 = IF_PCadd4;

        pw = m_out && !m_drop && ack && !flush;
        chk("imem_req", {31'd0, IMem_Req}, {31'd0, m_out});
        if (m_out) chk("imem_addr", IMem_Addr, m_addr);
        chk("pcwre", {31'd0, PCWre_from_Fetch_Unit}, {31'd0, pw});
        chk("if_valid", {31'd0, IF_Valid}, {31'd0, (q.size() != 0)});
        if (q.size() != 0) begin
            chk("if_pc", IF_PC, q[0].pc);
            chk("if_instr", IF_Instruction, q[0].instr);
            chk("if_pcadd4", IF_PCadd4, q[0].pc + 32'd4);
            if (!stall && !flush) pops.push_back(IF_PC);
        end
        if (PCWre_from_Fetch_Unit) pw_count++;

        sz = q.size();
        if (flush) q.delete();
        else begin
            if (sz != 0 && !stall) void'(q.pop_front());
            if (pw) q.push_back('{pc: m_addr, instr: rdata});
        end
        if (m_out) begin
            if (ack) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (flush) begin
                m_drop = 1'b1;
            end
        end else if (sz < DEPTH && !flush) begin
            m_out  = 1'b1;
            m_addr = pc_src;
        end
        if (flush)   pc_src = flush_target;
        else if (pw) pc_src = pc_src + 32'd4;
    endtask

    // Asynchronous reset pulse between clock edges; checked before any edge.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Flush       = 1'b0;
        currAddress = pc_src;
        Reset       = 1'b0;
        IMem_Ack    = 1'b1;
        #1;
        chk("rst_req", {31'd0, IMem_Req}, 32'd0);
        chk("rst_addr", IMem_Addr, 32'd0);
        chk("rst_valid", {31'd0, IF_Valid}, 32'd0);
        chk("rst_pcwre", {31'd0, PCWre_from_Fetch_Unit}, 32'd0);
        IMem_Ack = 1'b0;
        q.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        #1;
        Reset = 1'b1;
        // First edge after release issues a request from currAddress.
        m_out  = 1'b1;
        m_addr = pc_src;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        pw_count    = 0;
        Reset       = 1'b1;
        Flush       = 1'b0;
        IMem_Ack    = 1'b0;
        IMem_RData  = 32'd0;
        ID_Stall    = 1'b0;
        currAddress = 32'd0;
        m_out       = 1'b0;
        m_drop      = 1'b0;
        m_addr      = 32'd0;
        pc_src      = 32'd0;
        flush_target = 32'd0;

        // Single fetch, ack after two wait cycles.
        pc_src = 32'h0;
        do_reset();
        pw_count = 0;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h20080005);
        chk("s031_pcwre_now", {31'd0, obs_pcwre}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk("s031_valid", {31'd0, obs_valid}, 32'd1);
        chk("s031_pc", obs_pc, 32'h0);
        chk("s031_pcadd4", obs_pcadd4, 32'h4);
        chk("s031_instr", obs_instr, 32'h20080005);
        chk("s031_pulses", pw_count, 32'd1);

        // Fill under stall, then drain in order.
        pc_src = 32'h0;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0, m_out, 1'b1, $urandom);
        chk("s032_full_noreq", {31'd0, obs_req}, 32'd0);
        chk("s032_full_valid", {31'd0, obs_valid}, 32'd1);
        pops.delete();
        for (int i = 0; i < 10; i++) cycle(1'b0, m_out, 1'b0, $urandom);
        chk("s032_npops", {31'd0, (pops.size() >= 4)}, 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < pops.size()) chk("s032_order", pops[i], 32'(i * 4));

        // Flush while request is outstanding: DROP, discard, redirect.
        pc_src = 32'h40;
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        flush_target = 32'h64;
        cycle(1'b1, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        chk("s033_drop_pcwre", {31'd0, obs_pcwre}, 32'd0);
        chk("s033_drop_req", {31'd0, obs_req}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk("s033_valid", {31'd0, obs_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk("s033_redirect", obs_addr, 32'h64);

        // Flush coincident with ack: no push, back to idle.
        flush_target = 32'h80;
        cycle(1'b1, 1'b1, 1'b1, 32'h12345678);
        chk("s034_pcwre", {31'd0, obs_pcwre}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk("s034_idle", {31'd0, obs_req}, 32'd0);
        chk("s034_valid", {31'd0, obs_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        chk("s034_next_addr", obs_addr, 32'h80);

        // Sustained traffic with mixed stalls: wrap and simultaneous push/pop.
        pw_count = 0;
        for (int i = 0; i < 40; i++)
            cycle(1'b0, m_out, ($urandom_range(0, 9) < 3), $urandom);
        chk("s035_ten_fetches", {31'd0, (pw_count >= 10)}, 32'd1);

        // Reset in the middle of a request (checks inside do_reset).
        while (!m_out) cycle(1'b0, 1'b0, 1'b1, 32'h0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic f;
            f = ($urandom_range(0, 15) == 0);
            if (f) flush_target = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8
                                                              : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(f, m_out && ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 4), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
